// File: rtl/riscv_constants.sv
`default_nettype none
// ============================================================================
// Module   : riscv_constants (package)
// Purpose  : Shared RV32I opcode encodings, register-file write-enable
//            encoding and immediate-format selection helper.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_constants;

    // Register-file write-enable encoding shared by decode and writeback
    localparam int                RF_WEN      = 1;
    localparam logic [RF_WEN-1:0] RF_WRITE    = 1'b1;
    localparam logic [RF_WEN-1:0] RF_NO_WRITE = 1'b0;

    // RV32I base opcodes (inst[6:0])
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    // Immediate layouts
    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    // Map an opcode to the immediate layout it carries
    function automatic imm_fmt_e imm_format(input logic [6:0] opcode);
        imm_fmt_e fmt;
        fmt = IMM_NONE;
        case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: fmt = IMM_I;
            OPC_STORE:                      fmt = IMM_S;
            OPC_BRANCH:                     fmt = IMM_B;
            OPC_LUI, OPC_AUIPC:             fmt = IMM_U;
            OPC_JAL:                        fmt = IMM_J;
            default:                        fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_immgen.sv
`default_nettype none
// ============================================================================
// Module   : riscv_immgen
// Purpose  : Combinational immediate generator; extracts and sign-extends
//            the immediate selected by the instruction opcode.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_immgen
    import riscv_constants::*;
(
    input  logic [31:0] inst,
    output logic [31:0] imm
);

    imm_fmt_e fmt;

    assign fmt = imm_format(inst[6:0]);

    // Reassemble the immediate bits for the selected layout; bit 31 is the sign
    always_comb begin
        imm = 32'd0;
        case (fmt)
            IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                            inst[11:8], 1'b0};
            IMM_U:   imm = {inst[31:12], 12'd0};
            IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                            inst[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/riscv_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : riscv_decode_stage
// Purpose  : RV32I instruction decode with register-file read, writeback
//            bypass, load-use interlock and ID/EX pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_decode_stage
    import riscv_constants::*;
#(
    parameter int WORD_LENGTH = 32,
    parameter int ADDR_LENGTH = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   if_valid,
    output logic                   if_ready,
    input  logic [31:0]            if_inst,
    input  logic [WORD_LENGTH-1:0] if_pc,
    input  logic                   flush,
    output logic [ADDR_LENGTH-1:0] rf_read_addr1,
    output logic [ADDR_LENGTH-1:0] rf_read_addr2,
    input  logic [WORD_LENGTH-1:0] rf_read_data1,
    input  logic [WORD_LENGTH-1:0] rf_read_data2,
    input  logic [RF_WEN-1:0]      wb_wen,
    input  logic [ADDR_LENGTH-1:0] wb_addr,
    input  logic [WORD_LENGTH-1:0] wb_data,
    output logic                   ex_valid,
    input  logic                   ex_ready,
    output logic [WORD_LENGTH-1:0] ex_pc,
    output logic [WORD_LENGTH-1:0] ex_rs1_val,
    output logic [WORD_LENGTH-1:0] ex_rs2_val,
    output logic [WORD_LENGTH-1:0] ex_imm,
    output logic [ADDR_LENGTH-1:0] ex_rd,
    output logic [RF_WEN-1:0]      ex_rf_wen,
    output logic [6:0]             ex_opcode,
    output logic [2:0]             ex_funct3,
    output logic                   ex_funct7b5,
    output logic                   ex_is_load,
    output logic                   ex_illegal
);

    // Instruction fields
    logic [6:0]             opcode;
    logic [ADDR_LENGTH-1:0] rd;
    logic [ADDR_LENGTH-1:0] rs1;
    logic [ADDR_LENGTH-1:0] rs2;
    logic [2:0]             funct3;

    assign opcode = if_inst[6:0];
    assign rd     = if_inst[11:7];
    assign funct3 = if_inst[14:12];
    assign rs1    = if_inst[19:15];
    assign rs2    = if_inst[24:20];

    assign rf_read_addr1 = rs1;
    assign rf_read_addr2 = rs2;

    // Immediate
    logic [31:0] imm;

    riscv_immgen u_immgen (
        .inst (if_inst),
        .imm  (imm)
    );

    // Opcode classification
    logic uses_rs2;
    logic writes_rd;
    logic is_legal;
    logic is_load;

    // Classify the opcode: which need rs2, which write rd, which are legal
    always_comb begin
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        is_legal  = 1'b1;
        case (opcode)
            OPC_OP: begin
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_STORE, OPC_BRANCH: uses_rs2 = 1'b1;
            OPC_OP_IMM, OPC_LOAD, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR:
                writes_rd = 1'b1;
            OPC_SYSTEM, OPC_MISC_MEM: is_legal = 1'b1;
            default: is_legal = 1'b0;
        endcase
    end

    assign is_load = (opcode == OPC_LOAD);

    // Operand selection: x0 reads zero, then writeback bypass, then RF data
    logic [WORD_LENGTH-1:0] rs1_val;
    logic [WORD_LENGTH-1:0] rs2_val;

    // Resolve each source operand with writeback forwarding
    always_comb begin
        rs1_val = rf_read_data1;
        rs2_val = rf_read_data2;
        if (rs1 == '0)
            rs1_val = '0;
        else if (wb_wen == RF_WRITE && wb_addr == rs1)
            rs1_val = wb_data;
        if (rs2 == '0)
            rs2_val = '0;
        else if (wb_wen == RF_WRITE && wb_addr == rs2)
            rs2_val = wb_data;
    end

    // Handshake and interlock
    logic hazard;
    logic stall;
    logic accept;

    assign hazard = ex_valid && ex_is_load && (ex_rd != '0) &&
                    ((ex_rd == rs1) || (uses_rs2 && (ex_rd == rs2)));
    assign stall  = ex_valid && !ex_ready;
    // A flush always drains the fetch side, whatever the back end is doing
    assign if_ready = flush ? 1'b1 : (!stall && !hazard);
    assign accept   = if_valid && if_ready;

    // ID/EX register: flush > stall hold > load > bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_val  <= '0;
            ex_rs2_val  <= '0;
            ex_imm      <= '0;
            ex_rd       <= '0;
            ex_rf_wen   <= RF_NO_WRITE;
            ex_opcode   <= '0;
            ex_funct3   <= '0;
            ex_funct7b5 <= 1'b0;
            ex_is_load  <= 1'b0;
            ex_illegal  <= 1'b0;
        end else if (flush) begin
            ex_valid  <= 1'b0;
            ex_rf_wen <= RF_NO_WRITE;
        end else if (stall) begin
            ex_valid  <= ex_valid;
        end else if (accept) begin
            ex_valid    <= 1'b1;
            ex_pc       <= if_pc;
            ex_rs1_val  <= rs1_val;
            ex_rs2_val  <= rs2_val;
            ex_imm      <= imm;
            ex_rd       <= rd;
            ex_rf_wen   <= (writes_rd && rd != '0) ? RF_WRITE : RF_NO_WRITE;
            ex_opcode   <= opcode;
            ex_funct3   <= funct3;
            ex_funct7b5 <= if_inst[30];
            ex_is_load  <= is_load;
            ex_illegal  <= !is_legal;
        end else begin
            // Bubble: hazard or idle fetch; suppress any stale write enable
            ex_valid  <= 1'b0;
            ex_rf_wen <= RF_NO_WRITE;
        end
    end

endmodule
`default_nettype wire
